// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register (main + skid) with flush and NOP bubble output.
// Optional stall/flush statistics counters are enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_reg #(
  parameter int                DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE = {64'h0, 32'h00000013}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_SKID_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_vld;
  logic              skid_vld;
  logic              in_fire;
  logic              out_fire;

  // Handshake: a beat transfers on a port in any cycle where valid and ready
  // are both high at the rising edge; valid never waits on ready.
  assign main_vld  = (state_q != ST_EMPTY);
  assign skid_vld  = (state_q == ST_FULL);
  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_vld ? main_q : BUBBLE;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flush drops everything held; an output fire this cycle has already left.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
    main_q <= main_d;
    skid_q <= skid_d;
  end

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, default 96, payload width in bits (PC, pc4, instr for IF/ID use).
REQ-002 Parameter: BUBBLE, default {64'h0, 32'h00000013}, DATA_W-wide value driven on out_data when no valid beat is held (NOP).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: flush  input  1  discards all held beats (branch/jump redirect).
REQ-006 Port: in_valid  input  1  upstream beat present.
REQ-007 Port: in_ready  output  1  stage can accept a beat this cycle.
REQ-008 Port: in_data  input  DATA_W  upstream payload.
REQ-009 Port: out_valid  output  1  downstream beat present.
REQ-010 Port: out_ready  input  1  downstream accepts; deasserted for a load-use stall.
REQ-011 Port: out_data  output  DATA_W  downstream payload.

Function
REQ-012 Storage: one main entry and one skid entry, each with payload and valid flag; state EMPTY (none valid), ONE (main only), FULL (main and skid).
REQ-013 in_ready SHALL be a function of registered state only (state != FULL), with no combinational path from out_ready or in_valid.
REQ-014 out_valid SHALL equal the main valid flag; out_data SHALL equal the main payload when out_valid=1, else BUBBLE.
REQ-015 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-016 EMPTY: input fire -> ONE, main <= in_data; else stay.
REQ-017 ONE: input and output fire -> ONE, main <= in_data; input fire only -> FULL, skid <= in_data; output fire only -> EMPTY; neither -> hold.
REQ-018 FULL: output fire -> ONE, main <= skid; else hold; in_valid ignored (in_ready=0).
REQ-019 Beats SHALL leave in acceptance order; no beat dropped or duplicated except by flush/rst.
REQ-020 Latency: a beat accepted at edge N SHALL appear on out_data at cycle N+1 when the stage was EMPTY or draining.
REQ-021 Sustained throughput SHALL be one beat per cycle when in_valid=out_ready=1.
REQ-022 flush=1 SHALL, at the next edge, clear both valid flags (state EMPTY); any input fire in the same cycle is discarded; any output fire in the same cycle still completes downstream.
REQ-023 Priority: rst > flush > handshake update.
REQ-024 Held payload SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-025 On rst at a clock edge: state EMPTY, both valid flags 0, out_valid=0, in_ready=1, out_data=BUBBLE, counters (REQ-027) 0.
REQ-026 rst asserted mid-transfer SHALL discard held beats with no output fire in the following cycle.

Configuration
REQ-027 Macro PIPE_SKID_STATS_EN defined: add outputs stall_cnt[31:0] (cycles with out_valid=1 & out_ready=0) and flush_cnt[15:0] (cycles with flush=1); both saturate at all-ones and are cleared only by rst.
REQ-028 Macro undefined: stall_cnt and flush_cnt ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset: rst=1 for 2 cycles -> out_valid=0, in_ready=1, out_data=96'h...00000013.
REQ-030 Streaming: in_valid=1, in_data=1,2,3,4, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, one cycle after acceptance.
REQ-031 Stall fill: accept A, out_ready=0, offer B, C -> B into skid, in_ready=0, C held upstream; out_ready=1 -> A, B, C in order, no gaps after release.
REQ-032 Flush in FULL with in_valid=1 (D) -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1; D never appears.
REQ-033 Sync reset while FULL -> next cycle EMPTY; asserting rst without a clock edge changes nothing.
REQ-034 With PIPE_SKID_STATS_EN: 5 stalled cycles, 2 flush cycles -> stall_cnt=5, flush_cnt=2; forced near-max -> saturates, no wrap.
